// File: rtl/alu_arbiter_pkg.sv
// ============================================================================
// Module   : alu_arbiter_pkg
// Purpose  : Shared op codes, FSM state encoding and defaults for alu_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_arbiter_pkg;

    localparam logic [1:0] c_op_add = 2'b00;
    localparam logic [1:0] c_op_sub = 2'b01;
    localparam logic [1:0] c_op_mul = 2'b10;
    localparam logic [1:0] c_op_div = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_issue = 2'd1;
    localparam state_t c_st_wait  = 2'd2;
    localparam state_t c_st_resp  = 2'd3;

    localparam int c_default_timeout = 63;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
    } alu_cmd_t;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_rr.sv
// ============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-way round-robin grant; ptr selects the preferred requester.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // Under contention the requester named by ptr wins; a lone request always wins.
    assign gnt[0] = req[0] & (~ptr | ~req[1]);
    assign gnt[1] = req[1] & ( ptr | ~req[0]);

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Arbitrates two requesters onto one multi-cycle ALU with timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int TIMEOUT = c_default_timeout
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [1:0]  op0,
    input  logic [1:0]  op1,
    input  logic [7:0]  a0,
    input  logic [7:0]  b0,
    input  logic [7:0]  a1,
    input  logic [7:0]  b1,
    output logic        ack0,
    output logic        ack1,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_reset,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic [15:0] rsp_result,
    output logic        busy
);

    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_rr_ptr;
    logic [7:0]  r_cnt;
    alu_cmd_t    r_cmd;
    logic        r_gnt_id;
    logic        r_err;
    logic [15:0] r_result;

    logic [1:0]  w_gnt;
    logic        w_idle;
    logic        w_drive;
    logic        w_resp;

    rr_arbiter2 u_rr (
        .req (({req1, req0})),
        .ptr (r_rr_ptr),
        .gnt (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_rr_ptr <= 1'b0;
            r_cnt    <= 8'd0;
            r_cmd    <= '0;
            r_gnt_id <= 1'b0;
            r_err    <= 1'b0;
            r_result <= 16'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (|w_gnt) begin
                        r_gnt_id <= w_gnt[1];
                        r_cmd    <= w_gnt[1] ? alu_cmd_t'{op1, a1, b1}
                                             : alu_cmd_t'{op0, a0, b0};
                        r_err    <= 1'b0;
                        r_result <= 16'd0;
                        r_state  <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_cnt   <= 8'd0;
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    // A completion on the final wait cycle beats the timeout.
                    if (alu_done) begin
                        r_result <= alu_result;
                        r_err    <= 1'b0;
                        r_state  <= c_st_resp;
                    end else if (r_cnt == c_cnt_last) begin
                        r_result <= 16'd0;
                        r_err    <= 1'b1;
                        r_state  <= c_st_resp;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_st_resp: begin
                    r_rr_ptr <= ~r_gnt_id;
                    r_state  <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign w_idle  = (r_state == c_st_idle);
    assign w_drive = (r_state == c_st_issue) || (r_state == c_st_wait);
    assign w_resp  = (r_state == c_st_resp);

    // The ack is issued in the grant cycle itself, so it follows req combinationally.
    assign ack0 = w_idle & ~reset & w_gnt[0];
    assign ack1 = w_idle & ~reset & w_gnt[1];

    assign alu_start  = (r_state == c_st_issue);
    assign alu_op     = w_drive ? r_cmd.op : 2'd0;
    assign alu_a      = w_drive ? r_cmd.a  : 8'd0;
    assign alu_b      = w_drive ? r_cmd.b  : 8'd0;
    assign alu_reset  = w_resp & r_err;
    assign rsp_valid  = w_resp;
    assign rsp_id     = w_resp & r_gnt_id;
    assign rsp_err    = w_resp & r_err;
    assign rsp_result = w_resp ? r_result : 16'd0;
    assign busy       = ~w_idle;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter (TIMEOUT = 10).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [1:0]  op0, op1;
    logic [7:0]  a0, b0, a1, b1;
    logic        ack0, ack1;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic        alu_reset;
    logic        alu_done;
    logic [15:0] alu_result;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [15:0] rsp_result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int early    = 0;

    alu_arbiter #(.TIMEOUT(10)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_reset(alu_reset), .alu_done(alu_done), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_result(rsp_result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; op0 = 2'd0; op1 = 2'd0;
        a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0;
        alu_done = 1'b0; alu_result = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_start", alu_start, 0);
        chk("rst_alu_a", alu_a, 0);
        reset = 1'b0;

        // Single request: ADD 5+3, done two cycles after start
        cyc(); req0 = 1'b1; op0 = c_op_add; a0 = 8'd5; b0 = 8'd3; #1;
        chk("t1_ack0", ack0, 1);
        chk("t1_ack1", ack1, 0);
        chk("t1_start_idle", alu_start, 0);
        cyc(); req0 = 1'b0; #1;
        chk("t1_start", alu_start, 1);
        chk("t1_op", alu_op, 0);
        chk("t1_a", alu_a, 5);
        chk("t1_b", alu_b, 3);
        chk("t1_busy", busy, 1);
        chk("t1_ack0_issue", ack0, 0);
        cyc(); #1;
        chk("t1_start_wait", alu_start, 0);
        chk("t1_a_wait", alu_a, 5);
        cyc(); alu_done = 1'b1; alu_result = 16'd8; #1;
        cyc(); alu_done = 1'b0; #1;
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_rsp_result", rsp_result, 8);
        chk("t1_alu_reset", alu_reset, 0);
        cyc(); #1;
        chk("t1_rsp_clear", rsp_valid, 0);
        chk("t1_idle", busy, 0);

        // Contention: both held, grants alternate 0,1,0
        reset = 1'b1;
        cyc(); reset = 1'b0;
        req0 = 1'b1; op0 = c_op_mul; a0 = 8'd7; b0 = 8'd6;
        req1 = 1'b1; op1 = c_op_div; a1 = 8'd100; b1 = 8'd7; #1;
        chk("c1_ack0", ack0, 1);
        chk("c1_ack1", ack1, 0);
        cyc(); #1;
        chk("c1_op", alu_op, 2);
        chk("c1_a", alu_a, 7);
        chk("c1_b", alu_b, 6);
        cyc(); alu_done = 1'b1; alu_result = 16'd42; #1;
        cyc(); alu_done = 1'b0; #1;
        chk("c1_rsp_valid", rsp_valid, 1);
        chk("c1_rsp_id", rsp_id, 0);
        chk("c1_rsp_result", rsp_result, 42);
        chk("c1_no_ack_resp", ack1, 0);
        cyc(); #1;
        chk("c2_ack1", ack1, 1);
        chk("c2_ack0", ack0, 0);
        cyc(); #1;
        chk("c2_op", alu_op, 3);
        chk("c2_a", alu_a, 100);
        cyc(); alu_done = 1'b1; alu_result = 16'd14; #1;
        cyc(); alu_done = 1'b0; #1;
        chk("c2_rsp_id", rsp_id, 1);
        chk("c2_rsp_result", rsp_result, 14);
        cyc(); #1;
        chk("c3_ack0", ack0, 1);
        chk("c3_ack1", ack1, 0);
        cyc(); req0 = 1'b0; req1 = 1'b0; #1;
        chk("c3_op", alu_op, 2);

        // Late request arriving in WAIT is held off until after RESP
        cyc(); req1 = 1'b1; op1 = c_op_sub; a1 = 8'd9; b1 = 8'd4; #1;
        chk("late_ack_wait0", ack1, 0);
        cyc(); #1;
        chk("late_ack_wait1", ack1, 0);
        alu_done = 1'b1; alu_result = 16'd42;
        cyc(); alu_done = 1'b0; #1;
        chk("c3_rsp_id", rsp_id, 0);
        chk("c3_rsp_result", rsp_result, 42);
        chk("late_ack_resp", ack1, 0);
        cyc(); #1;
        chk("late_ack_idle", ack1, 1);
        cyc(); req1 = 1'b0; #1;
        chk("late_op", alu_op, 1);
        chk("late_a", alu_a, 9);
        chk("late_b", alu_b, 4);

        // Timeout: ALU never completes
        cyc(); #1;
        for (int i = 1; i < 10; i++) begin
            cyc();
            if (rsp_valid) early++;
        end
        chk("to_no_early_rsp", early, 0);
        cyc(); #1;
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_result", rsp_result, 0);
        chk("to_alu_reset", alu_reset, 1);
        chk("to_rsp_id", rsp_id, 1);
        cyc(); #1;
        chk("to_alu_reset_clear", alu_reset, 0);
        chk("to_idle", busy, 0);

        // Stray done in IDLE is ignored
        alu_done = 1'b1; alu_result = 16'h1234;
        cyc(); alu_done = 1'b0; #1;
        chk("stray_busy", busy, 0);
        chk("stray_rsp", rsp_valid, 0);

        // Done on the final WAIT cycle wins over timeout
        req0 = 1'b1; op0 = c_op_sub; a0 = 8'd200; b0 = 8'd1; #1;
        chk("last_ack0", ack0, 1);
        cyc(); req0 = 1'b0; #1;
        cyc(); #1;
        repeat (9) cyc();
        chk("last_no_rsp", rsp_valid, 0);
        alu_done = 1'b1; alu_result = 16'hABCD;
        cyc(); alu_done = 1'b0; #1;
        chk("last_rsp_valid", rsp_valid, 1);
        chk("last_rsp_err", rsp_err, 0);
        chk("last_rsp_result", rsp_result, 16'hABCD);
        chk("last_alu_reset", alu_reset, 0);
        cyc(); #1;

        // Reset in WAIT discards the operation silently
        req0 = 1'b1; op0 = c_op_add; a0 = 8'd1; b0 = 8'd2; #1;
        cyc(); req0 = 1'b0; #1;
        cyc(); #1;
        chk("mr_busy_wait", busy, 1);
        reset = 1'b1;
        cyc();
        chk("mr_busy", busy, 0);
        chk("mr_rsp", rsp_valid, 0);
        chk("mr_start", alu_start, 0);
        chk("mr_alu_reset", alu_reset, 0);
        chk("mr_alu_a", alu_a, 0);
        chk("mr_alu_b", alu_b, 0);
        reset = 1'b0;
        cyc(); #1;
        chk("mr_no_rsp", rsp_valid, 0);
        req1 = 1'b1; op1 = c_op_mul; a1 = 8'd3; b1 = 8'd5; #1;
        chk("mr_ack1", ack1, 1);
        cyc(); req1 = 1'b0; #1;
        chk("mr_start1", alu_start, 1);
        chk("mr_a1", alu_a, 3);
        chk("mr_b1", alu_b, 5);
        cyc(); alu_done = 1'b1; alu_result = 16'd15; #1;
        cyc(); alu_done = 1'b0; #1;
        chk("mr_rsp_id", rsp_id, 1);
        chk("mr_rsp_result", rsp_result, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
